// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the M-extension sequencer.
//   FUNCT7_MULDIV : funct7 value marking an M-extension OP instruction
//   md_op_e       : funct3 encodings of the eight M-ops
//   md_state_e    : sequencer FSM states
package riscv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative multiply/divide datapath, one bit per i_step.
//   clk, rst_n : clock, async active-low reset
//   i_load     : load magnitudes (hi=0, lo=a, b=b)
//   i_step     : perform one shift-add (multiply) or restoring-divide step
//   i_div      : 1 = divide step, 0 = multiply step
//   i_a_mag    : |rs1|, multiplier or dividend
//   i_b_mag    : |rs2|, multiplicand or divisor
//   o_hi       : product high half / remainder
//   o_lo       : product low half / quotient
module muldiv_iter_dp #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_div,
    input  logic [XLEN-1:0] i_a_mag,
    input  logic [XLEN-1:0] i_b_mag,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;

    logic [XLEN:0]   w_add_a;
    logic [XLEN:0]   w_add_b;
    logic            w_cin;
    logic [XLEN+1:0] w_sum;
    logic            w_ge;

    // One XLEN+1 adder serves both modes. Divide subtracts b from the
    // shifted remainder (invert + carry-in); the carry-out means it fits.
    always_comb begin
        if (i_div) begin
            w_add_a = {r_hi, r_lo[XLEN-1]};
            w_add_b = ~{1'b0, r_b};
            w_cin   = 1'b1;
        end else begin
            w_add_a = {1'b0, r_hi};
            w_add_b = r_lo[0] ? {1'b0, r_b} : '0;
            w_cin   = 1'b0;
        end
    end

    assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, w_cin};
    assign w_ge  = w_sum[XLEN+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_load) begin
            r_hi <= '0;
            r_lo <= i_a_mag;
            r_b  <= i_b_mag;
        end else if (i_step) begin
            if (i_div) begin
                r_hi <= w_ge ? w_sum[XLEN-1:0] : w_add_a[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_ge};
            end else begin
                // Product shifts right through hi:lo as multiplier bits retire.
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M sequencer for the Execute stage: runs one M-op over the iterative
// datapath, stalls F/D/E while busy and strobes the result for one cycle.
//   clk, rst_n  : clock, async active-low reset
//   md_start_e  : valid M-op in Execute
//   funct3_e    : M-op select (md_op_e)
//   src_a_e     : rs1 value
//   src_b_e     : rs2 value
//   flush_e     : Execute flush, aborts the op
//   stall_md    : hold PC, F/D and D/E
//   md_result_e : result, qualified by md_valid_e
//   md_valid_e  : one-cycle result strobe
//
// state | meaning
// IDLE  | waiting for md_start_e; latches operands on start
// BUSY  | one datapath step per cycle, XLEN steps
// DONE  | result presented with md_valid_e for one cycle
module muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit FAST_SPEC = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            md_start_e,
    input  logic [2:0]      funct3_e,
    input  logic [XLEN-1:0] src_a_e,
    input  logic [XLEN-1:0] src_b_e,
    input  logic            flush_e,
    output logic            stall_md,
    output logic [XLEN-1:0] md_result_e,
    output logic            md_valid_e
);

    localparam int              CW   = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);

    md_state_e       r_state, w_state_nxt;
    logic [CW-1:0]   r_count;
    md_op_e          r_op;
    logic            r_neg_a, r_neg_b, r_special;
    logic [XLEN-1:0] r_spec_res, r_result;

    md_op_e          w_op;
    logic            w_start, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
    logic            w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_spec_res;
    logic [XLEN-1:0] w_hi, w_lo, w_q, w_r, w_final;
    logic [2*XLEN-1:0] w_prod;

    assign w_op    = md_op_e'(funct3_e);
    assign w_start = (r_state == MD_IDLE) && md_start_e && !flush_e;

    // MUL low half is sign-agnostic, so it runs unsigned.
    assign w_sgn_a = (w_op == MD_MULH) || (w_op == MD_MULHSU) || (w_op == MD_DIV) || (w_op == MD_REM);
    assign w_sgn_b = (w_op == MD_MULH) || (w_op == MD_DIV) || (w_op == MD_REM);
    assign w_neg_a = w_sgn_a && src_a_e[XLEN-1];
    assign w_neg_b = w_sgn_b && src_b_e[XLEN-1];
    assign w_a_mag = w_neg_a ? -src_a_e : src_a_e;
    assign w_b_mag = w_neg_b ? -src_b_e : src_b_e;

    // Divide-by-zero and signed overflow have architecturally fixed results.
    assign w_b_zero   = (src_b_e == '0);
    assign w_ovf      = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                        (src_a_e == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_e == '1);
    assign w_special  = funct3_e[2] && (w_b_zero || w_ovf);
    assign w_spec_res = w_b_zero ? (funct3_e[1] ? src_a_e : '1)
                                 : (funct3_e[1] ? '0 : src_a_e);

    always_comb begin
        w_state_nxt = r_state;
        stall_md    = 1'b0;
        md_valid_e  = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (md_start_e && !flush_e) begin
                    stall_md    = 1'b1;
                    w_state_nxt = (FAST_SPEC && w_special) ? MD_DONE : MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (flush_e) begin
                    w_state_nxt = MD_IDLE;
                end else begin
                    stall_md = 1'b1;
                    if (r_count == LAST) w_state_nxt = MD_DONE;
                end
            end
            MD_DONE: begin
                md_valid_e  = !flush_e;
                w_state_nxt = MD_IDLE;
            end
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_start),
        .i_step  ((r_state == MD_BUSY) && !flush_e),
        .i_div   (r_op[2]),
        .i_a_mag (w_a_mag),
        .i_b_mag (w_b_mag),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

    assign w_prod = (r_neg_a ^ r_neg_b) ? -{w_hi, w_lo} : {w_hi, w_lo};
    assign w_q    = (r_neg_a ^ r_neg_b) ? -w_lo : w_lo;
    assign w_r    = r_neg_a ? -w_hi : w_hi;

    always_comb begin
        w_final = '0;
        if (r_special) begin
            w_final = r_spec_res;
        end else begin
            case (r_op)
                MD_MUL:                        w_final = w_prod[XLEN-1:0];
                MD_MULH, MD_MULHSU, MD_MULHU:  w_final = w_prod[2*XLEN-1:XLEN];
                MD_DIV, MD_DIVU:               w_final = w_q;
                default:                       w_final = w_r;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= MD_IDLE;
            r_count    <= '0;
            r_op       <= MD_MUL;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
            r_result   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= ((r_state == MD_BUSY) && !flush_e) ? r_count + 1'b1 : '0;
            if (w_start) begin
                r_op       <= w_op;
                r_neg_a    <= w_neg_a;
                r_neg_b    <= w_neg_b;
                r_special  <= w_special;
                r_spec_res <= w_spec_res;
            end
            if (md_valid_e) r_result <= w_final;
        end
    end

    // Live value during DONE, then the captured copy until the next DONE.
    assign md_result_e = md_valid_e ? w_final : r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        md_start_e = 1'b0;
    logic [2:0]  funct3_e = 3'd0;
    logic [31:0] src_a_e = '0;
    logic [31:0] src_b_e = '0;
    logic        flush_e = 1'b0;
    logic        stall_md;
    logic [31:0] md_result_e;
    logic        md_valid_e;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32), .FAST_SPEC(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .md_start_e  (md_start_e),
        .funct3_e    (funct3_e),
        .src_a_e     (src_a_e),
        .src_b_e     (src_b_e),
        .flush_e     (flush_e),
        .stall_md    (stall_md),
        .md_result_e (md_result_e),
        .md_valid_e  (md_valid_e)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          spec;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Starts an op and keeps md_start_e high (D/E held) until the strobe.
    // lat = cycles after the start cycle until the strobe; stalls counted after start cycle.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int stalls,
                         output bit timeout);
        res = '0; lat = -1; stalls = 0; timeout = 1'b1;
        @(posedge clk); #1;
        md_start_e = 1'b1; funct3_e = f; src_a_e = a; src_b_e = b;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i > 0 && stall_md) stalls++;
            if (md_valid_e) begin
                res = md_result_e; lat = i; timeout = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        md_start_e = 1'b0;
    endtask

    task automatic no_strobe(input string nm, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (md_valid_e || stall_md) seen++;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    logic [31:0] res;
    int lat, stalls;
    bit tmo;

    initial begin
        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0}; // MUL 7*-3
        vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0}; // MULHU
        vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0}; // MULHSU -1*2
        vecs[3]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0}; // MULH
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0}; // DIV -7/2
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0}; // REM -7/2
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       1'b0}; // DIVU
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        1'b0}; // REMU
        vecs[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1}; // DIV /0
        vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1'b1}; // REM /0
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1}; // DIV ovf
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1}; // REM ovf
        vecs[12] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1}; // DIVU /0
        vecs[13] = '{3'd7, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1}; // REMU /0
        vecs[14] = '{3'd0, 32'h12345678, 32'd16,       32'h23456780, 1'b0}; // MUL
        vecs[15] = '{3'd4, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0}; // DIV by -1, no ovf

        #12;
        chk("reset_stall",  {31'd0, stall_md},   32'd0);
        chk("reset_valid",  {31'd0, md_valid_e}, 32'd0);
        chk("reset_result", md_result_e,          32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            do_op(vecs[k].f, vecs[k].a, vecs[k].b, res, lat, stalls, tmo);
            chk($sformatf("vec%0d_timeout", k), {31'd0, tmo}, 32'd0);
            chk($sformatf("vec%0d_result", k), res, vecs[k].exp);
            chk($sformatf("vec%0d_latency", k), 32'(lat), vecs[k].spec ? 32'd1 : 32'd33);
            chk($sformatf("vec%0d_stalls", k), 32'(stalls), vecs[k].spec ? 32'd0 : 32'd32);
            // Now in the IDLE cycle after DONE: strobe gone, result held.
            @(negedge clk);
            chk($sformatf("vec%0d_one_strobe", k), {31'd0, md_valid_e}, 32'd0);
            chk($sformatf("vec%0d_held", k), md_result_e, vecs[k].exp);
        end

        // Flush at BUSY count 10: stall drops in the same cycle, no strobe later.
        @(posedge clk); #1;
        md_start_e = 1'b1; funct3_e = 3'd0; src_a_e = 32'd7; src_b_e = 32'd3;
        for (int i = 0; i < 11; i++) @(negedge clk);
        chk("flush_pre_stall", {31'd0, stall_md}, 32'd1);
        flush_e = 1'b1; md_start_e = 1'b0;
        #1;
        chk("flush_stall_comb", {31'd0, stall_md}, 32'd0);
        @(posedge clk); #1;
        flush_e = 1'b0;
        no_strobe("flush_no_strobe", 40);
        chk("flush_result_kept", md_result_e, 32'h80000001);
        do_op(3'd5, 32'd9, 32'd3, res, lat, stalls, tmo);
        chk("after_flush_timeout", {31'd0, tmo}, 32'd0);
        chk("after_flush_divu", res, 32'd3);
        chk("after_flush_latency", 32'(lat), 32'd33);

        // Flush in IDLE blocks the start.
        @(posedge clk); #1;
        md_start_e = 1'b1; flush_e = 1'b1; funct3_e = 3'd5; src_a_e = 32'd8; src_b_e = 32'd2;
        #1;
        chk("idle_flush_stall", {31'd0, stall_md}, 32'd0);
        @(posedge clk); #1;
        md_start_e = 1'b0; flush_e = 1'b0;
        no_strobe("idle_flush_no_op", 40);

        // Reset at BUSY count 5: outputs clear at once, nothing afterwards.
        @(posedge clk); #1;
        md_start_e = 1'b1; funct3_e = 3'd3; src_a_e = 32'hFFFFFFFF; src_b_e = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) @(negedge clk);
        chk("rst_pre_stall", {31'd0, stall_md}, 32'd1);
        md_start_e = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst_mid_stall",  {31'd0, stall_md},   32'd0);
        chk("rst_mid_valid",  {31'd0, md_valid_e}, 32'd0);
        chk("rst_mid_result", md_result_e,          32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        no_strobe("rst_no_strobe", 40);
        do_op(3'd4, 32'hFFFFFF9C, 32'd7, res, lat, stalls, tmo);
        chk("after_rst_timeout", {31'd0, tmo}, 32'd0);
        chk("after_rst_div", res, 32'hFFFFFFF2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
